upsize_stream_arbiter: RTL and testbench
========================================

UPSIZE_STREAM_ARBITER -- requirements
Module: upsize_stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_IN, default 4: number of narrow requester streams (2..16).
REQ-002 SHALL have parameter IN_WIDTH, default 32: narrow beat width.
REQ-003 SHALL have parameter OUT_WIDTH, default 64: downstream upsizer word width; BEATS = OUT_WIDTH/IN_WIDTH, an integer >= 2.
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port din  input  NUM_IN*IN_WIDTH  packed requester data; slice i = din[i*IN_WIDTH +: IN_WIDTH].
REQ-007 SHALL have port vld_in  input  NUM_IN  per-requester valid.
REQ-008 SHALL have port rdy_upward  output  NUM_IN  per-requester ready.
REQ-009 SHALL have port en_mask  input  NUM_IN  requester enable; a 0 bit excludes that requester from arbitration.
REQ-010 SHALL have port dout  output  IN_WIDTH  selected beat to the upsizer.
REQ-011 SHALL have port vld_out  output  1  beat valid to the upsizer.
REQ-012 SHALL have port rdy_downward  input  1  upsizer ready.
REQ-013 SHALL have port grant_id  output  $clog2(NUM_IN)  index of the current/last granted requester.
REQ-014 SHALL have port busy  output  1  high while a grant is held.

Function
REQ-015 SHALL implement two states: IDLE and LOCK.
REQ-016 In IDLE, SHALL compute req = vld_in & en_mask and, if req != 0, pick the first set bit at or above rr_ptr, wrapping modulo NUM_IN.
REQ-017 On a pick, SHALL register grant_id = pick and move to LOCK on the next edge; IDLE holds all rdy_upward = 0, vld_out = 0, dout = 0.
REQ-018 In LOCK: vld_out = vld_in[grant_id]; rdy_upward[grant_id] = rdy_downward; all other rdy_upward bits = 0; dout = din slice grant_id.
REQ-019 A beat is accepted when LOCK && vld_out && rdy_downward; beat_cnt (width $clog2(BEATS)) SHALL increment on each accepted beat.
REQ-020 When an accepted beat has beat_cnt == BEATS-1, SHALL clear beat_cnt, set rr_ptr = (grant_id+1) mod NUM_IN, and return to IDLE.
REQ-021 The grant SHALL be held until exactly BEATS beats are accepted, regardless of vld_in[grant_id] gaps or en_mask changes, so one output word never mixes sources.
REQ-022 en_mask SHALL be sampled only in IDLE.
REQ-023 Each group SHALL cost one IDLE arbitration cycle, giving peak throughput of BEATS beats per BEATS+1 cycles.
REQ-024 rr_ptr SHALL change only on group completion.
REQ-025 A requester with no grant SHALL never see rdy_upward high.
REQ-026 busy SHALL equal (state == LOCK).
REQ-027 grant_id SHALL hold its value in IDLE until the next pick.

Reset
REQ-028 reset SHALL force, on the next edge: state = IDLE, rr_ptr = 0, beat_cnt = 0, grant_id = 0.
REQ-029 After reset, outputs SHALL be rdy_upward = 0, vld_out = 0, dout = 0, busy = 0.
REQ-030 reset asserted mid-LOCK SHALL abandon the partial group with no further handshakes; the downstream upsizer is reset by the same signal.

Structure
REQ-031 A shared package SHALL hold the state enum {IDLE, LOCK} and a function beats(OUT_WIDTH, IN_WIDTH) with an elaboration-time check of integer ratio >= 2.
REQ-032 The round-robin picker SHALL be a combinational sub-module rr_pick (inputs: req, ptr; outputs: pick, any), instanced once.

Verification (NUM_IN=4, IN_WIDTH=32, OUT_WIDTH=64, BEATS=2)
REQ-033 Stimulus: reset, then vld_in=0001, en_mask=1111, rdy_downward=1, din0 = A0, A1 -> IDLE one cycle, grant_id=0, then beats A0, A1 on consecutive cycles, busy falls, rr_ptr=1.
REQ-034 Stimulus: vld_in=1111 held -> grant order 0,1,2,3,0 with no requester skipped; each grant carries exactly 2 beats.
REQ-035 Stimulus: granted requester drops vld_in for 3 cycles after beat 1, others valid -> grant held, no other rdy_upward high, beat 2 accepted on return.
REQ-036 Stimulus: rdy_downward=0 for 5 cycles in LOCK -> dout/vld_out stable, beat_cnt unchanged, no acceptance.
REQ-037 Stimulus: en_mask=1010, vld_in=1111 -> grants alternate 1,3 only.
REQ-038 Stimulus: reset pulse after the first beat of a group -> next cycle busy = 0, beat_cnt = 0, rr_ptr = 0, and the next grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/upsize_stream_arbiter_pkg.sv
// Shared types and elaboration helpers for the upsizing stream arbiter.
package upsize_stream_arbiter_pkg;

   // Arbiter FSM: IDLE picks a requester, LOCK holds it for one full output word.
   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   // Number of narrow beats that make up one upsizer word.
   function automatic int beats(input int out_width, input int in_width);
      return out_width / in_width;
   endfunction

   // True when the width ratio is a whole number of at least two beats.
   function automatic bit ratio_ok(input int out_width, input int in_width);
      return (in_width > 0) && ((out_width % in_width) == 0) && ((out_width / in_width) >= 2);
   endfunction

endpackage

// File: rtl/upsize_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr, wrapping.
module rr_pick #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] pick,
   output logic         any
);

   int idx;

   // Scan offsets from the farthest down to ptr itself so the nearest request wins.
   always_comb begin
      pick = '0;
      idx  = 0;
      any  = |req;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N;
         if (req[idx]) begin
            pick = W'(idx);
         end
      end
   end

endmodule

// File: rtl/upsize_stream_arbiter.sv
// Round-robin arbiter feeding an upsizer: a grant is held for exactly BEATS
// accepted beats so one wide output word never mixes narrow sources.
//
// Handshake: a beat moves on any rising edge where valid and ready are both
// high on the same link; valid may not depend on ready from the other side,
// and here the arbiter only forwards vld_in/rdy_downward of the granted lane.
module upsize_stream_arbiter
   import upsize_stream_arbiter_pkg::*;
#(
   parameter int NUM_IN    = 4,
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 64
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_IN*IN_WIDTH-1:0]  din,
   input  logic [NUM_IN-1:0]           vld_in,
   output logic [NUM_IN-1:0]           rdy_upward,
   input  logic [NUM_IN-1:0]           en_mask,
   output logic [IN_WIDTH-1:0]         dout,
   output logic                        vld_out,
   input  logic                        rdy_downward,
   output logic [$clog2(NUM_IN)-1:0]   grant_id,
   output logic                        busy
);

   localparam int BEATS = beats(OUT_WIDTH, IN_WIDTH);
   localparam int ID_W  = $clog2(NUM_IN);
   localparam int CNT_W = $clog2(BEATS);

   if (!ratio_ok(OUT_WIDTH, IN_WIDTH)) begin : g_bad_ratio
      $error("OUT_WIDTH must be an integer multiple (>= 2) of IN_WIDTH");
   end
   if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
      $error("NUM_IN must be in 2..16");
   end

   state_t             state_q, state_d;
   logic [ID_W-1:0]    rr_ptr, ptr_d;
   logic [ID_W-1:0]    grant_d;
   logic [CNT_W-1:0]   beat_cnt, cnt_d;
   logic [NUM_IN-1:0]  req;
   logic [ID_W-1:0]    pick;
   logic               any;
   logic               accept;
   logic [IN_WIDTH-1:0] slice [NUM_IN];

   for (genvar g = 0; g < NUM_IN; g++) begin : g_slice
      assign slice[g] = din[g*IN_WIDTH +: IN_WIDTH];
   end

   // en_mask only matters while IDLE; in LOCK the pick result is ignored.
   assign req  = vld_in & en_mask;
   assign busy = (state_q == LOCK);

   rr_pick #(
      .N (NUM_IN),
      .W (ID_W)
   ) u_rr_pick (
      .req  (req),
      .ptr  (rr_ptr),
      .pick (pick),
      .any  (any)
   );

   // Next-state, grant bookkeeping and the granted lane's datapath/handshake.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_id;
      ptr_d      = rr_ptr;
      cnt_d      = beat_cnt;
      rdy_upward = '0;
      vld_out    = 1'b0;
      dout       = '0;
      accept     = 1'b0;
      case (state_q)
         IDLE: begin
            if (any) begin
               grant_d = pick;
               state_d = LOCK;
            end
         end
         LOCK: begin
            // Outputs are blanked during reset so an abandoned group makes no handshake.
            if (!reset) begin
               vld_out              = vld_in[grant_id];
               rdy_upward[grant_id] = rdy_downward;
               dout                 = slice[grant_id];
               accept               = vld_out && rdy_downward;
            end
            if (accept) begin
               if (beat_cnt == CNT_W'(BEATS - 1)) begin
                  cnt_d   = '0;
                  ptr_d   = (grant_id == ID_W'(NUM_IN - 1)) ? '0 : grant_id + ID_W'(1);
                  state_d = IDLE;
               end else begin
                  cnt_d = beat_cnt + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, pointer, grant and beat counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         beat_cnt <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr   <= ptr_d;
         grant_id <= grant_d;
         beat_cnt <= cnt_d;
      end
   end

endmodule

// File: tb/tb_upsize_stream_arbiter.sv
// Directed bench for upsize_stream_arbiter with an expected-beat scoreboard.
module tb_upsize_stream_arbiter;

   localparam int NUM_IN    = 4;
   localparam int IN_WIDTH  = 32;
   localparam int OUT_WIDTH = 64;
   localparam int ID_W      = 2;
   localparam int W         = ID_W + IN_WIDTH;

   logic                       clk = 1'b0;
   logic                       reset = 1'b1;
   logic [NUM_IN*IN_WIDTH-1:0] din;
   logic [NUM_IN-1:0]          vld_in;
   logic [NUM_IN-1:0]          rdy_upward;
   logic [NUM_IN-1:0]          en_mask = 4'hF;
   logic [IN_WIDTH-1:0]        dout;
   logic                       vld_out;
   logic                       rdy_downward = 1'b1;
   logic [ID_W-1:0]            grant_id;
   logic                       busy;

   int src_k [NUM_IN] = '{default: 0};
   int limit [NUM_IN] = '{default: 0};
   int exp_k [NUM_IN] = '{default: 0};
   logic [NUM_IN-1:0] gap = '0;

   logic [W-1:0] exp_q [$];
   logic [W-1:0] exp_w;
   logic         has_exp;

   int n_tests = 0;
   int n_fail  = 0;
   int n_cyc;
   int k_save;
   int k0_save;
   int k2_save;

   upsize_stream_arbiter #(
      .NUM_IN    (NUM_IN),
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .din          (din),
      .vld_in       (vld_in),
      .rdy_upward   (rdy_upward),
      .en_mask      (en_mask),
      .dout         (dout),
      .vld_out      (vld_out),
      .rdy_downward (rdy_downward),
      .grant_id     (grant_id),
      .busy         (busy)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] dval(input int i, input int k);
      return 32'hA000_0000 | (32'(i) << 16) | (32'(k) & 32'h0000_FFFF);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Requester model: each lane offers an increasing sequence until its limit.
   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         din[i*IN_WIDTH +: IN_WIDTH] = dval(i, src_k[i]);
         vld_in[i] = (src_k[i] < limit[i]) && !gap[i];
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < NUM_IN; i++) begin
         if (rdy_upward[i] && vld_in[i]) src_k[i] <= src_k[i] + 1;
      end
   end

   task automatic push_group(input int id, input int n);
      for (int j = 0; j < n; j++) begin
         exp_q.push_back({ID_W'(id), dval(id, exp_k[id])});
         exp_k[id]++;
      end
   endtask

   // Scoreboard / invariant monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!reset) begin
         if (busy) begin
            check("rdy_only_granted", 64'(rdy_upward & ~(4'b0001 << grant_id)), 64'd0);
         end else begin
            check("idle_rdy", 64'(rdy_upward), 64'd0);
            check("idle_vld", 64'(vld_out), 64'd0);
            check("idle_dout", 64'(dout), 64'd0);
         end
         if (vld_out && rdy_downward) begin
            has_exp = (exp_q.size() != 0);
            check("beat_expected", 64'(has_exp), 64'd1);
            if (has_exp) begin
               exp_w = exp_q.pop_front();
               check("beat_grant", 64'(grant_id), 64'(exp_w[W-1:IN_WIDTH]));
               check("beat_data", 64'(dout), 64'(exp_w[IN_WIDTH-1:0]));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string tag, input int max_cyc, output int n);
      n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while (!(!busy && exp_q.size() == 0) && n < max_cyc);
      check({tag, "_drain"}, 64'(!busy && exp_q.size() == 0), 64'd1);
   endtask

   initial begin
      // reset
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_vld_out", 64'(vld_out), 64'd0);
      check("rst_rdy", 64'(rdy_upward), 64'd0);
      check("rst_dout", 64'(dout), 64'd0);
      check("rst_grant", 64'(grant_id), 64'd0);
      check("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
      check("rst_beat_cnt", 64'(dut.beat_cnt), 64'd0);

      // single requester, one group
      tick();
      limit[0] = src_k[0] + 2;
      push_group(0, 2);
      @(negedge clk);
      check("single_idle_busy", 64'(busy), 64'd0);
      check("single_idle_vld", 64'(vld_out), 64'd0);
      tick();
      @(negedge clk);
      check("single_b0_busy", 64'(busy), 64'd1);
      check("single_b0_grant", 64'(grant_id), 64'd0);
      check("single_b0_cnt", 64'(dut.beat_cnt), 64'd0);
      tick();
      @(negedge clk);
      check("single_b1_busy", 64'(busy), 64'd1);
      check("single_b1_cnt", 64'(dut.beat_cnt), 64'd1);
      tick();
      @(negedge clk);
      check("single_done_busy", 64'(busy), 64'd0);
      check("single_done_ptr", 64'(dut.rr_ptr), 64'd1);
      check("single_done_cnt", 64'(dut.beat_cnt), 64'd0);
      check("single_grant_hold", 64'(grant_id), 64'd0);
      check("single_queue", 64'(exp_q.size()), 64'd0);

      // all valid from pointer 0: order 0,1,2,3,0 at 2 beats per 3 cycles
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      limit[0] = src_k[0] + 4;
      for (int i = 1; i < NUM_IN; i++) limit[i] = src_k[i] + 2;
      push_group(0, 2);
      push_group(1, 2);
      push_group(2, 2);
      push_group(3, 2);
      push_group(0, 2);
      wait_drain("rr_all", 60, n_cyc);
      check("rr_all_cycles", 64'(n_cyc), 64'd15);
      check("rr_all_ptr", 64'(dut.rr_ptr), 64'd1);

      // granted lane pauses for 3 cycles after its first beat
      for (int i = 1; i < NUM_IN; i++) limit[i] = src_k[i] + 2;
      push_group(1, 2);
      push_group(2, 2);
      push_group(3, 2);
      tick();
      tick();
      gap[1] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("gap_busy", 64'(busy), 64'd1);
         check("gap_grant", 64'(grant_id), 64'd1);
         check("gap_vld_out", 64'(vld_out), 64'd0);
         check("gap_rdy", 64'(rdy_upward), 64'b0010);
         check("gap_cnt", 64'(dut.beat_cnt), 64'd1);
         tick();
      end
      gap[1] = 1'b0;
      wait_drain("gap", 40, n_cyc);
      check("gap_ptr", 64'(dut.rr_ptr), 64'd0);

      // downstream stall for 5 cycles inside a group, en_mask dropped meanwhile
      k0_save = exp_k[0];
      limit[0] = src_k[0] + 2;
      push_group(0, 2);
      tick();
      rdy_downward = 1'b0;
      en_mask = 4'h0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall_busy", 64'(busy), 64'd1);
         check("stall_vld_out", 64'(vld_out), 64'd1);
         check("stall_dout", 64'(dout), 64'(dval(0, k0_save)));
         check("stall_cnt", 64'(dut.beat_cnt), 64'd0);
         check("stall_rdy", 64'(rdy_upward), 64'd0);
         tick();
      end
      en_mask = 4'hF;
      rdy_downward = 1'b1;
      wait_drain("stall", 20, n_cyc);

      // masked requesters 0 and 2 never win
      k_save = src_k[0];
      k2_save = src_k[2];
      en_mask = 4'b1010;
      for (int i = 0; i < NUM_IN; i++) limit[i] = src_k[i] + 4;
      push_group(1, 2);
      push_group(3, 2);
      push_group(1, 2);
      push_group(3, 2);
      wait_drain("mask", 60, n_cyc);
      check("mask_req0_idle", 64'(src_k[0]), 64'(k_save));
      check("mask_req2_idle", 64'(src_k[2]), 64'(k2_save));
      check("mask_ptr", 64'(dut.rr_ptr), 64'd0);
      limit[0] = src_k[0];
      limit[2] = src_k[2];
      en_mask = 4'hF;

      // reset after the first beat of a group
      k2_save = src_k[2];
      limit[2] = k2_save + 2;
      push_group(2, 2);
      tick();
      tick();
      reset = 1'b1;
      exp_q.delete();
      exp_k[2] = k2_save + 1;
      limit[1] = src_k[1] + 2;
      limit[2] = limit[2] + 1;
      limit[3] = src_k[3] + 2;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_cnt", 64'(dut.beat_cnt), 64'd0);
      check("midrst_ptr", 64'(dut.rr_ptr), 64'd0);
      check("midrst_grant", 64'(grant_id), 64'd0);
      check("midrst_src2", 64'(src_k[2]), 64'(k2_save + 1));
      push_group(1, 2);
      push_group(2, 2);
      push_group(3, 2);
      wait_drain("midrst", 40, n_cyc);

      tick();
      check("final_queue", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
